// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame buffer and its frame parser.
package led_pkg;

  localparam int         LED_ROWS     = 8;
  localparam int         FRAME_BYTES  = 27;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // One display row: {R, G, B} column masks, 8 columns per colour.
  typedef logic [23:0] rgb_row_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_BRT,
    ST_CSUM,
    ST_DISCARD
  } frame_state_e;

  // Replace one colour lane of a row: col 0 = R [23:16], 1 = G [15:8], 2 = B [7:0].
  function automatic rgb_row_t set_lane(rgb_row_t row, logic [1:0] col, logic [7:0] data);
    rgb_row_t res;
    res = row;
    case (col)
      2'd0:    res[23:16] = data;
      2'd1:    res[15:8]  = data;
      default: res[7:0]   = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/led_frame_parser.sv
// Frame parser: walks the 27-byte frame (header, 24 pixel bytes, brightness,
// checksum), emits back-buffer write strobes and a one-cycle good/bad verdict
// in the same cycle as the deciding byte or frame_end.
module led_frame_parser
  import led_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [1:0] wr_col,
  output logic [7:0] wr_byte,
  output logic       brt_wr,
  output logic       frame_good,
  output logic       frame_bad
);

  frame_state_e state, state_nxt;
  logic [2:0]   row_cnt, row_nxt;
  logic [1:0]   col_cnt, col_nxt;
  logic [7:0]   sum, sum_nxt;

  // State, row/colour counters and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      sum     <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state   <= state_nxt;
      row_cnt <= row_nxt;
      col_cnt <= col_nxt;
      sum     <= sum_nxt;
    end
  end

  // Next-state, counter update and strobe decode. frame_start overrides
  // everything (latest frame wins); frame_end overrides a same-cycle byte.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt  = state;
    row_nxt    = row_cnt;
    col_nxt    = col_cnt;
    sum_nxt    = sum;
    wr_en      = 1'b0;
    brt_wr     = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    wr_row     = row_cnt;
    wr_col     = col_cnt;
    wr_byte    = rx_byte;

    if (frame_start) begin
      state_nxt = ST_HDR;
      row_nxt   = '0;
      col_nxt   = '0;
      sum_nxt   = '0;
    end else if (frame_end) begin
      // Ending while a frame is still open means it was short.
      case (state)
        ST_HDR, ST_PAYLOAD, ST_BRT, ST_CSUM: frame_bad = 1'b1;
        default: ;
      endcase
      state_nxt = ST_IDLE;
    end else if (rx_valid) begin
      case (state)
        ST_HDR: begin
          if (rx_byte == HDR_BYTE) begin
            state_nxt = ST_PAYLOAD;
          end else begin
            frame_bad = 1'b1;
            state_nxt = ST_DISCARD;
          end
        end
        ST_PAYLOAD: begin
          wr_en   = 1'b1;
          sum_nxt = sum + rx_byte;
          if (col_cnt == 2'd2) begin
            col_nxt = '0;
            row_nxt = row_cnt + 3'd1;
            if (row_cnt == 3'(LED_ROWS - 1)) state_nxt = ST_BRT;
          end else begin
            col_nxt = col_cnt + 2'd1;
          end
        end
        ST_BRT: begin
          brt_wr    = 1'b1;
          sum_nxt   = sum + rx_byte;
          state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_byte == sum) begin
            frame_good = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_nxt  = ST_DISCARD;
          end
        end
        default: ;  // IDLE and DISCARD ignore bytes
      endcase
    end
  end

endmodule

// File: rtl/led_frame_buffer.sv
// LED frame buffer: ping-pong 8x24-bit frame store between the SPI byte
// receiver and the row scanner. New frames land in the back buffer and are
// swapped to the front only on a scanner frame boundary.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  input  logic                 frame_sync,
  input  logic [2:0]           rd_row,
  output logic [23:0]          rd_data,
  output logic [2:0]           brightness,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic       wr_en;
  logic [2:0] wr_row;
  logic [1:0] wr_col;
  logic [7:0] wr_byte;
  logic       brt_wr;
  logic       frame_good;
  logic       frame_bad;

  rgb_row_t   mem [2][LED_ROWS];
  logic       front_sel;
  logic       back_sel;
  logic       pending;
  logic [2:0] back_brt;
  logic       swap;

  led_frame_parser #(
    .HDR_BYTE (HDR_BYTE)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_byte     (wr_byte),
    .brt_wr      (brt_wr),
    .frame_good  (frame_good),
    .frame_bad   (frame_bad)
  );

  // pending can only be set after a completed frame and is cleared by the
  // next frame_start, so no swap ever happens while the back side is written.
  assign back_sel = ~front_sel;
  assign swap     = frame_sync & pending;

  // Frame store: parser writes land in the back buffer, one colour lane at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the store is reset because both buffers must read as all-zero after reset.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < LED_ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[back_sel][wr_row] <= set_lane(mem[back_sel][wr_row], wr_col, wr_byte);
    end
  end

  // Swap, pending flag, brightness shadow, verdict pulses and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel  <= 1'b0;
      pending    <= 1'b0;
      back_brt   <= '0;
      brightness <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (swap) begin
        front_sel  <= ~front_sel;
        brightness <= back_brt;
      end
      // Swap uses the old pending value, so a same-cycle frame_start still swaps.
      if (frame_start)     pending <= 1'b0;
      else if (frame_good) pending <= 1'b1;
      else if (swap)       pending <= 1'b0;

      if (brt_wr) back_brt <= wr_byte[2:0];

      frame_ok  <= frame_good;
      frame_err <= frame_bad;
      if (frame_bad && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  // Registered read of the displayed buffer, one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[front_sel][rd_row];
  end

endmodule

// File: doc/led_frame_buffer.md
Name: led_frame_buffer

Overview:
- Sits between the SPI byte receiver and the LED row-scan driver.
- Parses validated 27-byte frames from the byte stream into a ping-pong 8x24-bit frame store.
- Swaps the new frame to the display side only at a scanner frame boundary, so no tearing occurs.
- Supplies row RGB data and the 3-bit brightness to the scanner.

Parameters:
- HDR_BYTE, 8'hA5, required first byte of every frame.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse, CS falling edge (synchronised upstream)
- frame_end  in  1  one-cycle pulse, CS rising edge
- rx_byte  in  8  received byte, MSB-first assembled
- rx_valid  in  1  one-cycle strobe qualifying rx_byte
- frame_sync  in  1  one-cycle pulse from scanner at row 7->0 wrap
- rd_row  in  3  row index requested by scanner
- rd_data  out  24  {R[7:0],G[7:0],B[7:0]} column masks of rd_row, front buffer
- brightness  out  3  brightness of the displayed frame
- frame_ok  out  1  pulse: frame validated, swap pending
- frame_err  out  1  pulse: frame rejected
- err_cnt  out  ERR_CNT_W  saturating count of rejected frames

Behaviour:
- Reset values:
  - rd_data=0, brightness=0, frame_ok=0, frame_err=0, err_cnt=0.
  - Both buffers zero, front_sel=0, pending=0, back brightness=0, FSM=IDLE.
- Frame format: byte0=HDR_BYTE; bytes1..24 pixel data; byte25 brightness in [2:0], bits [7:3] ignored; byte26 checksum.
- Pixel mapping: byte k, k=1..24, goes to row (k-1)/3 and colour (k-1)%3. Colour 0 is R in [23:16], 1 is G in [15:8], 2 is B in [7:0].
- Row and colour are tracked with counters; no divider is used.
- Checksum: 8-bit sum modulo 256 of bytes 1..25.
- FSM states: IDLE, HDR, PAYLOAD, BRT, CSUM, DISCARD.
  - frame_start in any state: go to HDR, clear counters and running sum, clear pending (latest frame wins).
  - HDR, rx_valid: byte==HDR_BYTE goes to PAYLOAD; otherwise frame_err and go to DISCARD.
  - PAYLOAD, rx_valid: write byte into the back buffer, add to sum. After the 24th byte go to BRT.
  - BRT, rx_valid: latch back brightness, add to sum, go to CSUM.
  - CSUM, rx_valid: byte==sum sets pending, pulses frame_ok, goes to IDLE. Mismatch pulses frame_err and goes to DISCARD.
  - DISCARD: ignore bytes until frame_start.
  - IDLE: ignore rx_valid. Bytes after the checksum are ignored and are not an error.
  - frame_end in HDR, PAYLOAD, BRT or CSUM: frame_err (short frame), go to IDLE.
  - frame_end in IDLE or DISCARD: go to IDLE, no error.
- frame_ok and frame_err assert the cycle after the deciding byte. They never both assert in one cycle.
- err_cnt increments on every frame_err and saturates at all-ones.
- Swap: frame_sync with pending=1 toggles front_sel, copies back brightness to the brightness output, and clears pending. frame_sync with pending=0 has no effect.
- After a swap, the back buffer is the old front buffer. Its contents are stale until overwritten; they are never displayed before a full valid frame rewrites them.
- Simultaneous events:
  - frame_sync and frame_start in the same cycle: the swap occurs first, then the new frame targets the new back buffer.
  - frame_sync in the same cycle as the frame_ok-setting byte: no swap; the swap happens at the next frame_sync.
- Read path: rd_data is registered from front[rd_row] with 1-cycle latency. rd_data reflects front_sel from the cycle after the swap.
- Reset mid-frame: everything returns to reset values; the partial frame is lost with no error pulse.

Decomposition:
- Shared package led_pkg:
  - constants LED_ROWS=8, FRAME_BYTES=27, HDR_BYTE_DEF=8'hA5;
  - typedef rgb_row_t (24-bit), typedef frame_state_e.
- One sub-module, led_frame_parser, holds the FSM, counters, checksum and error logic. It emits wr_en, wr_row, wr_col, wr_byte, brt_wr, frame_good and frame_bad.
- The top module holds the ping-pong storage, swap logic and read register.

Test Plan:
- Valid frame check:
  - Stimulus: A5, 24 x 8'h01, 8'h05, checksum 8'h1D, then frame_sync.
  - Response: frame_ok pulse, then after sync rd_data=24'h010101 for every row with 1-cycle latency, brightness=5, err_cnt=0.
- Bad checksum: the same frame with checksum 8'h1E gives frame_err, err_cnt=1, and after frame_sync rd_data and brightness are unchanged (0).
- Bad header: first byte 8'h5A gives frame_err one cycle after that byte. The following 26 bytes are ignored and no frame_ok is raised.
- Short frame: frame_end after 10 payload bytes gives frame_err and err_cnt+1. The previously displayed frame persists across frame_sync.
- Swap timing:
  - Stimulus: valid frame A (R rows=8'hFF), sync, valid frame B (B rows=8'hFF); then frame_sync asserted together with a new frame_start.
  - Response: display switches to B (rd_data=24'h0000FF); the new frame writes into A's buffer.
  - Also: 256 bad frames leave err_cnt saturated at 8'hFF.
- Reset mid-frame: assert rst_n=0 after 12 bytes. All outputs return to zero; a subsequent valid frame is accepted normally.
